// File: rtl/sha.sv
// Shared SHA definitions: algorithm select, message block layout and padding helpers.
package sha;

    typedef enum logic [2:0] {
        sha1   = 3'd0,
        sha224 = 3'd1,
        sha256 = 3'd2,
        sha384 = 3'd3,
        sha512 = 3'd4
    } mode_t;

    // Word 0 sits in the most significant bits so that w64[i] = {word 2i, word 2i+1}.
    // 512-bit blocks occupy words 0..15 and leave words 16..31 at zero.
    typedef union packed {
        logic [0:31][31:0] w32;
        logic [0:15][63:0] w64;
    } msg_t;

    localparam logic [7:0] PAD_MARKER = 8'h80;

    // Number of 32-bit words in one block for the given algorithm.
    function automatic logic [5:0] block_words(mode_t m);
        return (m == sha384 || m == sha512) ? 6'd32 : 6'd16;
    endfunction

    // Number of 32-bit words taken by the trailing bit-length field.
    function automatic logic [2:0] len_words(mode_t m);
        return (m == sha384 || m == sha512) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/sha_padder.sv
// FIPS 180-4 message padder: packs 32-bit big-endian beats into blocks,
// appends the 0x80 marker, zero fill and the big-endian bit length.
module sha_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_keep,
    input  logic        in_last,
    input  sha::mode_t  in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output sha::msg_t   out_msg,
    output sha::mode_t  out_mode,
    output logic        out_first,
    output logic        out_last
);
    import sha::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       widx_q, widx_d;
    logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
    mode_t            mode_q, mode_d;
    msg_t             msg_q, msg_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             seen_last_q, seen_last_d;
    logic             marker_q, marker_d;
    logic             spill_q, spill_d;

    mode_t            cur_mode;
    logic [5:0]       bw;
    logic [5:0]       len_start;
    logic [5:0]       widx_ext;
    logic             at_end;
    logic             in_len;
    logic [2:0]       keep_eff;
    logic             beat_marker;
    logic [31:0]      beat_word;
    logic [5:0]       beat_bits;
    logic [0:3][31:0] len_field;
    logic [31:0]      pad_word;

    // Keep the first nbytes bytes of a word, drop the marker right after them, zero the rest.
    function automatic logic [31:0] merge_marker(logic [31:0] w, logic [1:0] nbytes);
        logic [31:0] r;
        case (nbytes)
            2'd0:    r = {PAD_MARKER, 24'h000000};
            2'd1:    r = {w[31:24], PAD_MARKER, 16'h0000};
            2'd2:    r = {w[31:16], PAD_MARKER, 8'h00};
            default: r = {w[31:8], PAD_MARKER};
        endcase
        return r;
    endfunction

    // Block geometry for the active message and decode of the incoming beat.
    always_comb begin
        cur_mode    = (state_q == IDLE) ? in_mode : mode_q;
        bw          = block_words(cur_mode);
        len_start   = bw - {3'd0, len_words(cur_mode)};
        widx_ext    = {1'b0, widx_q};
        at_end      = (widx_ext == bw - 6'd1);
        in_len      = (widx_ext >= len_start);
        keep_eff    = (in_keep > 3'd4) ? 3'd4 : in_keep;
        beat_marker = in_last && (keep_eff != 3'd4);
        beat_word   = beat_marker ? merge_marker(in_data, keep_eff[1:0]) : in_data;
        beat_bits   = in_last ? {keep_eff, 3'b000} : 6'd32;
        len_field   = 128'(bitcnt_q);
    end

    // Next-state logic: fill words from the input, then pad, then hand the block off.
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        bitcnt_d    = bitcnt_q;
        mode_d      = mode_q;
        msg_d       = msg_q;
        first_d     = first_q;
        last_d      = last_q;
        seen_last_d = seen_last_q;
        marker_d    = marker_q;
        spill_d     = spill_q;
        pad_word    = '0;

        case (state_q)
            IDLE, FILL: begin
                if (in_valid) begin
                    if (state_q == IDLE) begin
                        mode_d      = in_mode;
                        first_d     = 1'b1;
                        last_d      = 1'b0;
                        seen_last_d = 1'b0;
                        marker_d    = 1'b0;
                        spill_d     = 1'b0;
                        bitcnt_d    = LEN_W'(beat_bits);
                    end else begin
                        bitcnt_d    = bitcnt_q + LEN_W'(beat_bits);
                    end
                    msg_d.w32[widx_q] = beat_word;
                    widx_d = widx_q + 5'd1;
                    if (in_last) begin
                        seen_last_d = 1'b1;
                    end
                    // A marker landing inside the length field pushes the length into a new block.
                    if (beat_marker) begin
                        marker_d = 1'b1;
                        spill_d  = in_len;
                    end
                    if (at_end) begin
                        state_d = EMIT;
                    end else if (in_last) begin
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PAD: begin
                if (!marker_q) begin
                    pad_word = {PAD_MARKER, 24'h000000};
                    marker_d = 1'b1;
                    spill_d  = in_len;
                end else if (in_len && !spill_q) begin
                    pad_word = len_field[widx_q[1:0]];
                end else begin
                    pad_word = '0;
                end
                msg_d.w32[widx_q] = pad_word;
                widx_d = widx_q + 5'd1;
                if (at_end) begin
                    state_d = EMIT;
                    last_d  = !spill_d;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    widx_d  = '0;
                    msg_d   = '0;
                    spill_d = 1'b0;
                    if (last_q) begin
                        state_d     = IDLE;
                        seen_last_d = 1'b0;
                        marker_d    = 1'b0;
                    end else if (seen_last_q) begin
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and block registers; reset discards any partial message.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            widx_q      <= '0;
            bitcnt_q    <= '0;
            mode_q      <= sha1;
            msg_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            seen_last_q <= 1'b0;
            marker_q    <= 1'b0;
            spill_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            bitcnt_q    <= bitcnt_d;
            mode_q      <= mode_d;
            msg_q       <= msg_d;
            first_q     <= first_d;
            last_q      <= last_d;
            seen_last_q <= seen_last_d;
            marker_q    <= marker_d;
            spill_q     <= spill_d;
        end
    end

    assign in_ready  = (state_q == IDLE) || (state_q == FILL);
    assign out_valid = (state_q == EMIT);
    assign out_msg   = msg_q;
    assign out_mode  = mode_q;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule

// File: doc/sha_padder.md
# sha_padder

Upstream message formatter for `sha_engine`. It accepts a byte-granular message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: the `0x80` marker, zero fill, and the big-endian bit-length field. It emits complete 512-bit blocks (sha1/sha224/sha256) or 1024-bit blocks (sha384/sha512) on a valid/ready handshake, in the `sha::msg_t` format the engine loads.

## Interface
Parameters:
- `LEN_W`, default 64: width of the message bit-length counter. Counts beyond 2^LEN_W−1 bits wrap silently.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  padder accepts a word this cycle.
- `in_data`  in  32  message word; byte 0 is in [31:24].
- `in_keep`  in  3  count of valid bytes (0–4), upper bytes first. Only meaningful with `in_last`; 0 is legal only for the empty message.
- `in_last`  in  1  final word of the message.
- `in_mode`  in  `sha::mode_t`  algorithm; sampled on the first beat of each message.
- `out_valid`  out  1  block available.
- `out_ready`  in  1  downstream accepts the block.
- `out_msg`  out  `sha::msg_t`  block contents.
  - `w32[i]` is message word i of the block.
  - `w64[i]` = {word 2i, word 2i+1}.
- `out_mode`  out  `sha::mode_t`  mode latched for this message.
- `out_first`  out  1  block is the first block of its message.
- `out_last`  out  1  block is the final (length-bearing) block.

## Operation
- Block size:
  - 16 words (64 B) for sha1/224/256, with a 64-bit length field in words 14–15.
  - 32 words (128 B) for sha384/512, with a 128-bit length field in words 28–31; words 28–29 are 0 when `LEN_W` ≤ 64.
- States:
  - IDLE: `in_ready`=1. The first beat latches the mode, clears the bit counter, sets the first flag, and goes to FILL (or PAD if that beat has `in_last`).
  - FILL: `in_ready`=1. Each handshake writes `out_msg` word `widx`, increments `widx`, and adds 32 (or 8·`in_keep` on the last beat) to the bit count.
    - When the block is full → EMIT.
    - When `in_last` is accepted → PAD.
  - PAD: `in_ready`=0. Writes one word per cycle.
    - If the last beat had `in_keep`<4, the `0x80` byte is merged into that same word and the remaining bytes are zeroed.
    - If the last beat had `in_keep`=4, the next word is `0x80000000`.
    - Further words are zero.
    - If fewer than 2 (or 4) words remain before the length field → zero to the end, EMIT with `out_last`=0, then return to PAD with `marker_done` set.
    - Otherwise the length words are written, then EMIT with `out_last`=1.
  - EMIT: `out_valid`=1, `in_ready`=0. On `out_ready`:
    - clear `out_first`;
    - if `out_last` → IDLE;
    - else if the marker is pending/done → PAD;
    - else → FILL.
    - `widx` resets to 0.
- The mode is held constant for the whole message; `in_mode` on later beats is ignored.
- `in_keep` on beats without `in_last` is ignored (treated as 4).

## Timing
- Reset values:
  - `in_ready`=1 (IDLE), `out_valid`=0, `out_msg`=0, `out_mode`=`sha::sha1`, `out_first`=0, `out_last`=0.
  - Counters are 0.
- Input throughput is 1 word per cycle in FILL. `in_ready` is a registered-state decode with no combinational path from `out_ready`.
- `out_valid` rises the cycle after the final word of a block is written. `out_msg`, `out_mode`, `out_first` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- After an EMIT handshake in cycle t, FILL/PAD resumes at t+1, so the first new word is accepted at t+1.
- Padding latency is one cycle per remaining word. For a single-beat sha256 message, `out_valid` asserts 16 cycles after the beat is accepted.
- Bit-count arithmetic is modulo 2^LEN_W, and the length field is big-endian.
- Reset asserted mid-message aborts immediately: the partial block is discarded and the reset values above apply.

## Structure
- Package `sha` (existing) holds `mode_t` and `msg_t`. Add to it:
  - `block_words(mode_t)` → 16 or 32;
  - `len_words(mode_t)` → 2 or 4;
  - constant `PAD_MARKER` = 8'h80.
- Single module, no sub-module. The byte-merge for the marker is a small combinational function in the same file.

## Test plan
- sha256 "abc": one beat `0x61626300`, `in_keep`=3, `in_last` → one block:
  - `w32[0]`=`0x61626380`, `w32[1..14]`=0, `w32[15]`=`0x00000018`;
  - `out_first`=`out_last`=1;
  - `out_valid` 16 cycles after accept.
- sha512 empty message: `in_keep`=0, `in_last` → `w64[0]`=`0x8000000000000000`, all other words 0, length 0, single block.
- sha256 56-byte message (14 words, last `in_keep`=4) → two blocks:
  - block 1: `w32[14]`=`0x80000000`, `w32[15]`=0, `out_last`=0;
  - block 2: all zero except `w32[15]`=`0x000001C0`, `out_first`=0, `out_last`=1.
- sha256 64-byte message → block 1 is the raw data with `out_first`=1, `out_last`=0; block 2 has `w32[0]`=`0x80000000`, `w32[15]`=`0x00000200`.
- Backpressure: hold `out_ready`=0 for 10 cycles with `out_valid`=1 → `out_msg` unchanged, `in_ready`=0, no beats consumed; the block is released on the first `out_ready`.
- Drop `rstn` after 5 beats of a sha384 message → `out_valid`=0 and `in_ready`=1 after release; a new sha256 "abc" then produces the exact block from the first scenario.
